rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Sequences the single write port (WE/A3/WD) of reg_file_3bus in the non-pipelined RISC-V core.
- Two write requesters share the port: ALU writeback, which is fire-and-forget with absolute priority, and load writeback, which uses a valid/ready handshake into a DEPTH-entry FIFO.
- Provides a pending-write scoreboard query so decode can stall on RAW hazards against queued writes.
- Provides a starvation flag that asks the core to hold off ALU writebacks.

Parameters:
- Reg_size, 32, data width of a register
- Addr_bits, 5, register address width
- DEPTH, 2, load-writeback FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_alu asserts

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU writeback request this cycle (always accepted)
- alu_addr  in  Addr_bits  ALU destination register
- alu_data  in  Reg_size  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  FIFO can accept; transfer when mem_valid && mem_ready
- mem_addr  in  Addr_bits  load destination register
- mem_data  in  Reg_size  load data
- WE  out  1  regfile write enable (registered)
- A3  out  Addr_bits  regfile write address (registered)
- WD  out  Reg_size  regfile write data (registered)
- q_addr1, q_addr2  in  Addr_bits  decode source-register queries
- busy1, busy2  out  1  queried register has a pending write (combinational)
- pend_count  out  $clog2(DEPTH)+1  FIFO occupancy
- stall_alu  out  1  request core to withhold alu_valid (registered)

Behaviour:
- Reset (rst high at edge): WE=0, A3=0, WD=0, FIFO empty, pend_count=0, stall_alu=0, age counter=0.
- mem_ready = !rst && (pend_count < DEPTH). It is computed from registered count only, so no push occurs when full, even on a pop cycle.
- Load with mem_addr==0: accepted (handshake completes) and discarded, never enqueued.
- Grant rule, evaluated each cycle:
  - If alu_valid && alu_addr!=0: grant ALU.
  - Else if FIFO non-empty: pop the head and grant it.
  - Else: no grant.
- ALU with alu_addr==0: dropped, and it does not block a FIFO pop that cycle.
- Latency: the granted write appears on WE/A3/WD on the cycle after the request. The regfile commits it at the end of that cycle. WE=0 in any cycle that follows a cycle with no grant.
- Push and pop in the same cycle: allowed when not full. A push into an empty FIFO is not poppable until the next cycle (no same-cycle bypass).
- Squash rule: when the ALU is granted with address X, every valid FIFO entry with addr X is invalidated. Invalidated entries are still popped in order, but produce WE=0 and do not count toward busy. This preserves program order, since ALU writes are younger.
- busy_n = 1 if q_addr_n != 0 and it matches any valid un-squashed FIFO entry or the in-flight output register (WE && A3).
- Age counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on a pop or when the FIFO is empty.
  - stall_alu is set on the cycle after age reaches STARVE_LIMIT and stays set until the next pop. ALU still wins if alu_valid is asserted regardless.
- rst mid-operation: the FIFO contents are lost, and no write issues in the following cycle.
- Arithmetic: read/write pointers wrap modulo DEPTH; pend_count is 0..DEPTH.

Decomposition:
- Package rf_pkg:
  - Reg_size and Addr_bits defaults.
  - typedef wb_req_t {logic valid; logic [Addr_bits-1:0] addr; logic [Reg_size-1:0] data;}.
  - localparam X0 = 0.
- One sub-module: wb_fifo (parameterised DEPTH circular buffer with per-entry valid/squash bits and an address-match vector output). The arbiter, output register, age counter and busy logic live in rf_wb_arbiter.

Test Plan:
- Reset, then a single load: mem_valid=1, addr=5, data=100 for 1 cycle -> handshake completes; the next cycle pops the head; WE=1, A3=5, WD=100 on the following cycle; busy1=1 for q_addr1=5 until WE drops.
- Fill: 3 back-to-back loads (addr 1,2,3) with alu_valid=1 (addr 7) every cycle -> mem_ready=0 after 2 accepts; pend_count=2; stall_alu=1 after 4 waiting cycles; dropping alu_valid drains writes 1 then 2.
- Squash: queue load addr 9 data 50 while alu_valid is low, then alu_valid=1 (addr 9, data 77) before the pop -> WD=77 written; the later pop of the addr-9 entry gives WE=0; busy for 9 clears after the ALU write.
- x0 handling: ALU addr 0 plus a queued load addr 4 in the same cycle -> ALU dropped, load written; load addr 0 -> accepted, pend_count unchanged, no write.
- Reset mid-operation: FIFO holding 2 entries, rst=1 for 1 cycle -> pend_count=0, WE=0 the next cycle, mem_ready=1 after rst deasserts.
- Regfile integration: write addresses 1..31 with data 100+4*(i-1) via alternating ALU/load paths, then read back via reg_file_3bus RD1 -> all values match; x0 reads 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package rf_pkg;

    localparam int Reg_size  = 32;
    localparam int Addr_bits = 5;

    // Hard-wired zero register: writes to it are discarded.
    localparam int X0 = 0;

    typedef struct packed {
        logic                 valid;
        logic [Addr_bits-1:0] addr;
        logic [Reg_size-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Circular buffer of pending load writebacks.
// Each slot has a live bit that is cleared when a younger ALU write to the same
// register supersedes it. Per-slot address-match vectors feed the hazard check.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     squash,
    input  logic [AW-1:0]            squash_addr,
    input  logic [AW-1:0]            q_addr1,
    input  logic [AW-1:0]            q_addr2,
    output logic                     head_live,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         match1,
    output logic [DEPTH-1:0]         match2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Small buffer read combinationally: the head must be poppable in the
    // same cycle it is granted, so a registered-read RAM does not fit here.
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] live_reg;
    logic [DEPTH-1:0] live_next;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    assign count     = count_reg;
    assign head_live = live_reg[rd_ptr_reg];
    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    // Payload storage, written on push only (no reset needed).
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    // Live bits: squash kills matching entries; an entry arriving in the
    // same cycle as a squashing ALU write is older than it, so it dies too.
    always_comb begin
        live_next = live_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash && (addr_mem[i] == squash_addr)) begin
                live_next[i] = 1'b0;
            end
        end
        if (pop) begin
            live_next[rd_ptr_reg] = 1'b0;
        end
        if (push) begin
            live_next[wr_ptr_reg] = !(squash && (push_addr == squash_addr));
        end
    end

    // Pointers, occupancy and live bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            live_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            live_reg  <= live_next;
        end
    end

    // Hazard match: only live (queued, not superseded) entries count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match1[gi] = live_reg[gi] && (addr_mem[gi] == q_addr1);
        assign match2[gi] = live_reg[gi] && (addr_mem[gi] == q_addr2);
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between ALU writeback (absolute
// priority, fire-and-forget) and queued load writebacks, with RAW-hazard
// queries for decode and a starvation request to hold off the ALU.
module rf_wb_arbiter #(
    parameter int Reg_size     = rf_pkg::Reg_size,
    parameter int Addr_bits    = rf_pkg::Addr_bits,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [Addr_bits-1:0]   alu_addr,
    input  logic [Reg_size-1:0]    alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [Addr_bits-1:0]   mem_addr,
    input  logic [Reg_size-1:0]    mem_data,
    output logic                   WE,
    output logic [Addr_bits-1:0]   A3,
    output logic [Reg_size-1:0]    WD,
    input  logic [Addr_bits-1:0]   q_addr1,
    input  logic [Addr_bits-1:0]   q_addr2,
    output logic                   busy1,
    output logic                   busy2,
    output logic [$clog2(DEPTH):0] pend_count,
    output logic                   stall_alu
);

    import rf_pkg::*;

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int AGW = $clog2(STARVE_LIMIT + 1);
    localparam logic [Addr_bits-1:0] ZERO_ADDR = Addr_bits'(X0);

    logic                 alu_grant;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_push;
    logic                 head_live;
    logic [Addr_bits-1:0] head_addr;
    logic [Reg_size-1:0]  head_data;
    logic [DEPTH-1:0]     match1;
    logic [DEPTH-1:0]     match2;

    logic                 we_reg, we_next;
    logic [Addr_bits-1:0] a3_reg, a3_next;
    logic [Reg_size-1:0]  wd_reg, wd_next;
    logic [AGW-1:0]       age_reg, age_next;
    logic                 stall_reg, stall_next;

    // ALU writes to x0 are dropped and leave the port free for the FIFO.
    assign alu_grant  = alu_valid && (alu_addr != ZERO_ADDR);
    assign fifo_empty = (pend_count == '0);
    assign fifo_pop   = !alu_grant && !fifo_empty;
    // Ready uses the registered count only, so a full FIFO never takes a push
    // even in a cycle where it is also popping.
    assign mem_ready  = !rst && (pend_count < CW'(DEPTH));
    // Loads to x0 complete the handshake but are not queued.
    assign fifo_push  = mem_valid && mem_ready && (mem_addr != ZERO_ADDR);

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (Addr_bits),
        .DW    (Reg_size)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_addr   (mem_addr),
        .push_data   (mem_data),
        .pop         (fifo_pop),
        .squash      (alu_grant),
        .squash_addr (alu_addr),
        .q_addr1     (q_addr1),
        .q_addr2     (q_addr2),
        .head_live   (head_live),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (pend_count),
        .match1      (match1),
        .match2      (match2)
    );

    // Grant selection: ALU first, else FIFO head (squashed heads write nothing).
    always_comb begin
        we_next = 1'b0;
        a3_next = a3_reg;
        wd_next = wd_reg;
        if (alu_grant) begin
            we_next = 1'b1;
            a3_next = alu_addr;
            wd_next = alu_data;
        end else if (fifo_pop) begin
            we_next = head_live;
            a3_next = head_addr;
            wd_next = head_data;
        end
    end

    // Registered regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg <= 1'b0;
            a3_reg <= '0;
            wd_reg <= '0;
        end else begin
            we_reg <= we_next;
            a3_reg <= a3_next;
            wd_reg <= wd_next;
        end
    end

    // Head age (saturating) and the sticky starvation request cleared by a pop.
    always_comb begin
        age_next   = age_reg;
        stall_next = stall_reg;
        if (fifo_pop || fifo_empty) begin
            age_next = '0;
        end else if (age_reg < AGW'(STARVE_LIMIT)) begin
            age_next = age_reg + 1'b1;
        end
        if (fifo_pop) begin
            stall_next = 1'b0;
        end else if (age_next >= AGW'(STARVE_LIMIT)) begin
            stall_next = 1'b1;
        end
    end

    // Age and stall state.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_reg   <= '0;
            stall_reg <= 1'b0;
        end else begin
            age_reg   <= age_next;
            stall_reg <= stall_next;
        end
    end

    assign WE        = we_reg;
    assign A3        = a3_reg;
    assign WD        = wd_reg;
    assign stall_alu = stall_reg;

    // A register is busy if a live queued entry or the in-flight write targets it.
    assign busy1 = (q_addr1 != ZERO_ADDR) && ((|match1) || (we_reg && (a3_reg == q_addr1)));
    assign busy2 = (q_addr2 != ZERO_ADDR) && ((|match2) || (we_reg && (a3_reg == q_addr2)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model, and a regfile fill/readback.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, q_addr1, q_addr2, A3;
    logic [31:0] alu_data, mem_data, WD;
    logic        WE, busy1, busy2, stall_alu;
    logic [1:0]  pend_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rf_model [32];
    int          x0_writes = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .WE(WE), .A3(A3), .WD(WD),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .busy1(busy1), .busy2(busy2),
        .pend_count(pend_count), .stall_alu(stall_alu)
    );

    // Behavioural regfile: commits the port at the end of each cycle WE is high.
    always @(posedge clk) begin
        if (WE === 1'b1) begin
            if (A3 != 5'd0) rf_model[A3] <= WD;
            else            x0_writes <= x0_writes + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        q_addr1 = '0; q_addr2 = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; idle(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        tick(); tick();
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%0h exp=0", WE); end
        vectors++; if (A3 !== 5'd0) begin miscompares++; $display("FAIL reset_a3 got=%0h exp=0", A3); end
        vectors++; if (WD !== 32'd0) begin miscompares++; $display("FAIL reset_wd got=%0h exp=0", WD); end
        vectors++; if (pend_count !== 2'd0) begin miscompares++; $display("FAIL reset_pend got=%0h exp=0", pend_count); end
        vectors++; if (stall_alu !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%0h exp=0", stall_alu); end
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst got=%0h exp=0", mem_ready); end
        rst = 1'b0; #1;
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got=%0h exp=1", mem_ready); end
        $display("[tb] reset: outputs cleared, mem_ready released");
    endtask

    task automatic test_single_load();
        idle(); mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'd100; q_addr1 = 5'd5; #1;
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready got=%0h exp=1", mem_ready); end
        tick(); mem_valid = 1'b0; #1;
        vectors++; if (pend_count !== 2'd1) begin miscompares++; $display("FAIL load_pend got=%0h exp=1", pend_count); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL load_busy_queued got=%0h exp=1", busy1); end
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL load_we_early got=%0h exp=0", WE); end
        tick();
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd5, 32'd100}) begin miscompares++; $display("FAIL load_write got=%0h/%0h/%0h exp=1/5/64", WE, A3, WD); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL load_busy_inflight got=%0h exp=1", busy1); end
        vectors++; if (pend_count !== 2'd0) begin miscompares++; $display("FAIL load_pend_after got=%0h exp=0", pend_count); end
        tick();
        vectors++; if (WE !== 1'b0 || busy1 !== 1'b0) begin miscompares++; $display("FAIL load_done got=we%0h busy%0h exp=0/0", WE, busy1); end
        $display("[tb] single_load: addr=5 data=100 written");
    endtask

    task automatic test_fill();
        idle(); q_addr2 = 5'd7;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'd70;
        mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'd11;
        tick();                                    // F1
        mem_addr = 5'd2; mem_data = 32'd22; #1;
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd7, 32'd70}) begin miscompares++; $display("FAIL fill_alu_write got=%0h/%0h/%0h exp=1/7/46", WE, A3, WD); end
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready1 got=%0h exp=1", mem_ready); end
        tick();                                    // F2
        mem_addr = 5'd3; mem_data = 32'd33; #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready got=%0h exp=0", mem_ready); end
        vectors++; if (pend_count !== 2'd2) begin miscompares++; $display("FAIL fill_pend got=%0h exp=2", pend_count); end
        tick(); tick();                            // F4
        vectors++; if (stall_alu !== 1'b0) begin miscompares++; $display("FAIL fill_stall_early got=%0h exp=0", stall_alu); end
        vectors++; if (busy2 !== 1'b1) begin miscompares++; $display("FAIL fill_busy_alu got=%0h exp=1", busy2); end
        tick();                                    // F5
        vectors++; if (stall_alu !== 1'b1) begin miscompares++; $display("FAIL fill_stall got=%0h exp=1", stall_alu); end
        vectors++; if (pend_count !== 2'd2) begin miscompares++; $display("FAIL fill_pend_hold got=%0h exp=2", pend_count); end
        alu_valid = 1'b0;
        tick();                                    // F6
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd1, 32'd11}) begin miscompares++; $display("FAIL fill_drain1 got=%0h/%0h/%0h exp=1/1/b", WE, A3, WD); end
        vectors++; if (stall_alu !== 1'b0) begin miscompares++; $display("FAIL fill_stall_clear got=%0h exp=0", stall_alu); end
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_again got=%0h exp=1", mem_ready); end
        tick();                                    // F7
        mem_valid = 1'b0; #1;
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd2, 32'd22}) begin miscompares++; $display("FAIL fill_drain2 got=%0h/%0h/%0h exp=1/2/16", WE, A3, WD); end
        tick();                                    // F8
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd3, 32'd33}) begin miscompares++; $display("FAIL fill_drain3 got=%0h/%0h/%0h exp=1/3/21", WE, A3, WD); end
        tick();
        vectors++; if (WE !== 1'b0 || pend_count !== 2'd0) begin miscompares++; $display("FAIL fill_idle got=we%0h pend%0h exp=0/0", WE, pend_count); end
        $display("[tb] fill: loads 1,2,3 behind ALU x7, drained in order");
    endtask

    task automatic test_squash();
        idle(); mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'd50; q_addr1 = 5'd9;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'd77; #1;
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL squash_busy_pre got=%0h exp=1", busy1); end
        tick();
        alu_valid = 1'b0; #1;
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd9, 32'd77}) begin miscompares++; $display("FAIL squash_alu_write got=%0h/%0h/%0h exp=1/9/4d", WE, A3, WD); end
        vectors++; if (pend_count !== 2'd1) begin miscompares++; $display("FAIL squash_pend got=%0h exp=1", pend_count); end
        tick();
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL squash_pop_we got=%0h exp=0", WE); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL squash_busy_post got=%0h exp=0", busy1); end
        vectors++; if (pend_count !== 2'd0) begin miscompares++; $display("FAIL squash_pend_post got=%0h exp=0", pend_count); end
        $display("[tb] squash: ALU x9=77 supersedes queued load x9=50");
    endtask

    task automatic test_x0();
        idle(); mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'd44;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'd99;
        tick();
        alu_valid = 1'b0; #1;
        vectors++; if ({WE, A3, WD} !== {1'b1, 5'd4, 32'd44}) begin miscompares++; $display("FAIL x0_alu_drop got=%0h/%0h/%0h exp=1/4/2c", WE, A3, WD); end
        tick();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'd5; #1;
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL x0_load_ready got=%0h exp=1", mem_ready); end
        tick();
        mem_valid = 1'b0; #1;
        vectors++; if (pend_count !== 2'd0) begin miscompares++; $display("FAIL x0_load_pend got=%0h exp=0", pend_count); end
        tick();
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL x0_load_we got=%0h exp=0", WE); end
        $display("[tb] x0: ALU x0 dropped, load x0 discarded");
    endtask

    task automatic test_reset_mid();
        idle(); alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'd1;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'd2;
        tick();
        mem_addr = 5'd12; mem_data = 32'd3;
        tick();
        vectors++; if (pend_count !== 2'd2) begin miscompares++; $display("FAIL rstmid_pend_pre got=%0h exp=2", pend_count); end
        rst = 1'b1; idle(); #1;
        vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_in_rst got=%0h exp=0", mem_ready); end
        tick();
        rst = 1'b0; #1;
        vectors++; if (pend_count !== 2'd0) begin miscompares++; $display("FAIL rstmid_pend got=%0h exp=0", pend_count); end
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL rstmid_we got=%0h exp=0", WE); end
        vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got=%0h exp=1", mem_ready); end
        tick();
        vectors++; if (WE !== 1'b0) begin miscompares++; $display("FAIL rstmid_we2 got=%0h exp=0", WE); end
        $display("[tb] reset_mid: two queued loads discarded");
    endtask

    task automatic test_random();
        wb_req_t     mq[$];
        wb_req_t     h;
        logic        m_we, n_we, alu_g, accept, was_empty, popped, exp_b1, exp_b2;
        logic [4:0]  m_a3;
        logic [31:0] m_wd;
        logic [1:0]  exp_cnt;
        int          m_wait;
        int          bad;
        pulse_reset();
        m_we = 1'b0; m_a3 = '0; m_wd = '0; m_wait = 0; bad = 0;
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_addr  = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_valid = 1'($urandom_range(0, 1));
            mem_addr  = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            if (alu_valid && mem_valid && alu_addr == mem_addr && alu_addr != 5'd0) mem_addr = mem_addr ^ 5'd8;
            q_addr1 = 5'($urandom_range(0, 7));
            q_addr2 = 5'($urandom_range(0, 7));
            #1;
            exp_b1 = (q_addr1 != 0) && m_we && (m_a3 == q_addr1);
            exp_b2 = (q_addr2 != 0) && m_we && (m_a3 == q_addr2);
            foreach (mq[k]) begin
                if (mq[k].valid && q_addr1 != 0 && mq[k].addr == q_addr1) exp_b1 = 1'b1;
                if (mq[k].valid && q_addr2 != 0 && mq[k].addr == q_addr2) exp_b2 = 1'b1;
            end
            exp_cnt = 2'(mq.size());
            vectors++; if (WE !== m_we) begin miscompares++; bad++; $display("FAIL rnd_we c=%0d got=%0h exp=%0h", c, WE, m_we); end
            if (m_we) begin
                vectors++; if ({A3, WD} !== {m_a3, m_wd}) begin miscompares++; bad++; $display("FAIL rnd_wr c=%0d got=%0h/%0h exp=%0h/%0h", c, A3, WD, m_a3, m_wd); end
            end
            vectors++; if (pend_count !== exp_cnt) begin miscompares++; bad++; $display("FAIL rnd_pend c=%0d got=%0h exp=%0h", c, pend_count, exp_cnt); end
            vectors++; if (mem_ready !== (mq.size() < DEPTH)) begin miscompares++; bad++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, mem_ready, mq.size() < DEPTH); end
            vectors++; if (stall_alu !== (m_wait >= LIMIT)) begin miscompares++; bad++; $display("FAIL rnd_stall c=%0d got=%0h exp=%0h", c, stall_alu, m_wait >= LIMIT); end
            vectors++; if ({busy1, busy2} !== {exp_b1, exp_b2}) begin miscompares++; bad++; $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, busy1, busy2, exp_b1, exp_b2); end
            // Reference rules for the next cycle.
            alu_g     = alu_valid && alu_addr != 5'd0;
            accept    = mem_valid && (mq.size() < DEPTH);
            was_empty = (mq.size() == 0);
            popped    = !alu_g && !was_empty;
            n_we      = 1'b0;
            if (alu_g) begin
                n_we = 1'b1; m_a3 = alu_addr; m_wd = alu_data;
                foreach (mq[k]) if (mq[k].addr == alu_addr) mq[k].valid = 1'b0;
            end else if (popped) begin
                h = mq.pop_front();
                n_we = h.valid; m_a3 = h.addr; m_wd = h.data;
            end
            if (accept && mem_addr != 5'd0) mq.push_back('{valid: 1'b1, addr: mem_addr, data: mem_data});
            m_wait = (popped || was_empty) ? 0 : ((m_wait < LIMIT) ? m_wait + 1 : m_wait);
            m_we = n_we;
            tick();
        end
        idle();
        $display("[tb] random: 400 cycles, %0d cycle mismatches", bad);
    endtask

    task automatic test_regfile();
        int n;
        pulse_reset();
        for (int i = 1; i < 32; i++) begin
            idle();
            if (i % 2 == 1) begin
                alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'(100 + 4 * (i - 1));
                tick();
            end else begin
                mem_valid = 1'b1; mem_addr = 5'(i); mem_data = 32'(100 + 4 * (i - 1));
                #1; n = 0;
                while (mem_ready !== 1'b1 && n < 20) begin tick(); n++; end
                vectors++; if (n >= 20) begin miscompares++; $display("FAIL rf_handshake_timeout i=%0d got=ready%0h exp=1", i, mem_ready); end
                tick();
            end
        end
        idle();
        for (int k = 0; k < 8; k++) tick();
        for (int i = 1; i < 32; i++) begin
            vectors++; if (rf_model[i] !== 32'(100 + 4 * (i - 1))) begin miscompares++; $display("FAIL rf_read x%0d got=%0d exp=%0d", i, rf_model[i], 100 + 4 * (i - 1)); end
        end
        vectors++; if (x0_writes !== 0) begin miscompares++; $display("FAIL rf_x0_writes got=%0d exp=0", x0_writes); end
        $display("[tb] regfile: x1..x31 written via alternating ALU/load paths");
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_load();
        test_fill();
        test_squash();
        test_x0();
        test_reset_mid();
        test_random();
        test_regfile();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
